// File: rtl/tile_fetch_5x5.sv
// Line-buffered 5x5 tile extractor (stride 3) feeding a Winograd fast-convolution core.
// Loads rows from a raster stream, issues one tile per start pulse and waits for the core to finish.
module tile_fetch_5x5 #(
    parameter int QUANT = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    localparam int TR_W = $clog2((IMG_H - 2) / 3) + 1,
    localparam int TC_W = $clog2((IMG_W - 2) / 3) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [QUANT-1:0]      in_pixel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [25*QUANT-1:0]   tile_out,
    output logic                  conv_start,
    input  logic                  conv_done,
    output logic [TR_W-1:0]       tile_row,
    output logic [TC_W-1:0]       tile_col,
    output logic                  frame_done
);

    localparam int TILES_X = (IMG_W - 2) / 3;
    localparam int TILES_Y = (IMG_H - 2) / 3;
    localparam int CW      = $clog2(IMG_W);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [CW-1:0]     wr_col_r;
    logic [2:0]        wr_row_r;
    logic [2:0]        base_r;
    logic [2:0]        rows_needed_r;
    logic [TR_W-1:0]   tile_row_r;
    logic [TC_W-1:0]   tile_col_r;
    logic              in_ready_r;
    logic              conv_start_r;
    logic              frame_done_r;

    logic              accept_s;
    logic              row_end_s;
    logic              col_adv_s;
    logic              row_adv_s;
    logic              frame_end_s;
    logic [CW-1:0]     col_base_s;

    logic [QUANT-1:0]  lb_r [5][IMG_W];

    // Physical line-buffer row holding logical row (b + off), modulo the 5-row ring.
    function automatic logic [2:0] ring_row(input logic [2:0] b, input logic [2:0] off);
        logic [3:0] sum_v;
        sum_v = {1'b0, b} + {1'b0, off};
        if (sum_v >= 4'd5) begin
            ring_row = 3'(sum_v - 4'd5);
        end else begin
            ring_row = sum_v[2:0];
        end
    endfunction

    assign in_ready   = in_ready_r;
    assign conv_start = conv_start_r;
    assign frame_done = frame_done_r;
    assign tile_row   = tile_row_r;
    assign tile_col   = tile_col_r;

    assign accept_s   = in_valid && in_ready_r;
    assign row_end_s  = accept_s && (wr_col_r == CW'(IMG_W - 1));
    assign col_base_s = CW'(3 * int'(tile_col_r));

    // Next-state decode and tile-advance strobes.
    always_comb begin
        next_state_s = state_r;
        col_adv_s    = 1'b0;
        row_adv_s    = 1'b0;
        frame_end_s  = 1'b0;
        case (state_r)
            S_LOAD: begin
                if (row_end_s && (rows_needed_r == 3'd1)) begin
                    next_state_s = S_ISSUE;
                end else begin
                    next_state_s = S_LOAD;
                end
            end
            S_ISSUE: begin
                next_state_s = S_WAIT;
            end
            S_WAIT: begin
                if (!conv_done) begin
                    next_state_s = S_WAIT;
                end else if (tile_col_r < TC_W'(TILES_X - 1)) begin
                    col_adv_s    = 1'b1;
                    next_state_s = S_ISSUE;
                end else if (tile_row_r < TR_W'(TILES_Y - 1)) begin
                    row_adv_s    = 1'b1;
                    next_state_s = S_LOAD;
                end else begin
                    frame_end_s  = 1'b1;
                    next_state_s = S_LOAD;
                end
            end
            default: begin
                next_state_s = S_LOAD;
            end
        endcase
    end

    // Control state, write pointers, tile indices and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= S_LOAD;
            wr_col_r      <= {CW{1'b0}};
            wr_row_r      <= 3'd0;
            base_r        <= 3'd0;
            rows_needed_r <= 3'd5;
            tile_row_r    <= {TR_W{1'b0}};
            tile_col_r    <= {TC_W{1'b0}};
            in_ready_r    <= 1'b0;
            conv_start_r  <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            in_ready_r   <= (next_state_s == S_LOAD);
            conv_start_r <= (next_state_s == S_ISSUE);
            frame_done_r <= frame_end_s;
            if (row_end_s) begin
                wr_col_r      <= {CW{1'b0}};
                wr_row_r      <= ring_row(wr_row_r, 3'd1);
                rows_needed_r <= rows_needed_r - 3'd1;
            end else if (accept_s) begin
                wr_col_r <= wr_col_r + CW'(1);
            end
            if (col_adv_s) begin
                tile_col_r <= tile_col_r + TC_W'(1);
            end else if (row_adv_s) begin
                // The bottom two rows of the previous band are reused; only three new rows are streamed.
                tile_col_r    <= {TC_W{1'b0}};
                tile_row_r    <= tile_row_r + TR_W'(1);
                base_r        <= ring_row(base_r, 3'd3);
                rows_needed_r <= 3'd3;
            end else if (frame_end_s) begin
                tile_col_r    <= {TC_W{1'b0}};
                tile_row_r    <= {TR_W{1'b0}};
                base_r        <= 3'd0;
                wr_row_r      <= 3'd0;
                rows_needed_r <= 3'd5;
            end
        end
    end

    // Line-buffer storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb_r[wr_row_r][wr_col_r] <= in_pixel;
        end
    end

    // Tile view: element (i,j) from ring row base+i, column 3*tile_col+j.
    always_comb begin
        tile_out = {(25 * QUANT){1'b0}};
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                tile_out[(i * 5 + j) * QUANT +: QUANT] = lb_r[ring_row(base_r, 3'(i))][col_base_s + CW'(j)];
            end
        end
    end

endmodule

// File: tb/tb_tile_fetch_5x5.sv
// Scoreboard bench for tile_fetch_5x5: frames are modelled as 2-D images, expected tiles are
// sliced directly from them and checked by a monitor on every conv_start.
module tb_tile_fetch_5x5;

    localparam int Q    = 8;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int TX   = (W - 2) / 3;
    localparam int TY   = (H - 2) / 3;
    localparam int TR_W = $clog2(TY) + 1;
    localparam int TC_W = $clog2(TX) + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [Q-1:0]       in_pixel;
    logic               in_valid;
    logic               in_ready;
    logic [25*Q-1:0]    tile_out;
    logic               conv_start;
    logic               conv_done;
    logic [TR_W-1:0]    tile_row;
    logic [TC_W-1:0]    tile_col;
    logic               frame_done;

    tile_fetch_5x5 #(.QUANT(Q), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .tile_out(tile_out), .conv_start(conv_start), .conv_done(conv_done),
        .tile_row(tile_row), .tile_col(tile_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [25*Q-1:0] tile;
        int              t;
        int              c;
    } exp_t;

    exp_t          exp_q[$];
    logic [Q-1:0]  pix_q[$];
    logic [Q-1:0]  img [H][W];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = -10;
    int last_done = -10;
    int fd_cyc = -1;
    int fd_cnt = 0;
    int frame_pix = 0;
    int cur_t = 0;
    int cur_c = 0;
    int spur_cnt = 0;
    bit active = 1'b0;
    bit rdy_bad = 1'b0;
    bit tile_bad = 1'b0;
    bit acc_neg = 1'b0;
    bit gaps = 1'b0;
    bit spur_en = 1'b0;
    logic [25*Q-1:0] hold_tile;
    exp_t mon_e;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // mode 0: r*W+c, mode 1: 255-(r*W+c), otherwise random pixels
    task automatic push_frame(input int mode);
        exp_t e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (mode == 0)      img[r][c] = Q'(r * W + c);
                else if (mode == 1) img[r][c] = Q'(255 - (r * W + c));
                else                img[r][c] = Q'($urandom_range(0, 255));
                pix_q.push_back(img[r][c]);
            end
        end
        for (int t = 0; t < TY; t++) begin
            for (int c = 0; c < TX; c++) begin
                e.t = t;
                e.c = c;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        e.tile[(i * 5 + j) * Q +: Q] = img[3 * t + i][3 * c + j];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < 4000 && fd_cnt < n; k++) @(negedge clk);
        chk("frame_done_count", fd_cnt, n);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel source: pops a pixel once its handshake completed, optionally inserts gaps.
    initial begin
        in_valid = 1'b0;
        in_pixel = '0;
        forever begin
            @(posedge clk);
            if (reset) pix_q.delete();
            else if (acc_neg && pix_q.size() > 0) void'(pix_q.pop_front());
            #1;
            if (pix_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_pixel = pix_q[0];
            end else begin
                in_valid = 1'b0;
                in_pixel = Q'($urandom_range(0, 255));
            end
        end
    end

    // Core model: conv_done 9 cycles after conv_start, plus stray pulses outside WAIT.
    initial begin
        int cnt;
        cnt = 0;
        conv_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            conv_done = 1'b0;
            if (reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) conv_done = 1'b1;
                end
                if (conv_start) cnt = 9;
                if (spur_en && (in_ready || conv_start) && $urandom_range(0, 3) == 0) begin
                    conv_done = 1'b1;
                    spur_cnt++;
                end
            end
        end
    end

    // Monitor: handshake bookkeeping and scoreboard comparison at every tile issue.
    always @(negedge clk) begin
        if (reset) begin
            active    = 1'b0;
            frame_pix = 0;
            fd_cyc    = -1;
            acc_neg   = 1'b0;
            exp_q.delete();
        end else begin
            if (cyc == fd_cyc) begin
                chk("frame_done_pulse", frame_done, 1'b1);
            end else if (frame_done) begin
                chk("frame_done_extra", frame_done, 1'b0);
            end
            if (frame_done) begin
                fd_cnt++;
                frame_pix = 0;
            end
            acc_neg = in_valid && in_ready;
            if (acc_neg) begin
                frame_pix++;
                last_acc = cyc;
            end
            if (conv_start) begin
                chk("start_while_busy", active, 1'b0);
                chk("start_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("tile_data_t%0d_c%0d", mon_e.t, mon_e.c), tile_out, mon_e.tile);
                    chk("tile_row", tile_row, mon_e.t);
                    chk("tile_col", tile_col, mon_e.c);
                    if (mon_e.c == 0) begin
                        chk("load_latency", cyc, last_acc + 1);
                        chk("pixels_before_tile", frame_pix, (3 * mon_e.t + 5) * W);
                    end else begin
                        chk("issue_latency", cyc, last_done + 1);
                    end
                    cur_t = mon_e.t;
                    cur_c = mon_e.c;
                end
                active    = 1'b1;
                rdy_bad   = 1'b0;
                tile_bad  = 1'b0;
                hold_tile = tile_out;
            end else if (active) begin
                if (in_ready) rdy_bad = 1'b1;
                if (tile_out !== hold_tile) tile_bad = 1'b1;
                if (conv_done) begin
                    chk("ready_low_in_wait", rdy_bad, 1'b0);
                    chk("tile_stable_in_wait", tile_bad, 1'b0);
                    active    = 1'b0;
                    last_done = cyc;
                    if (cur_t == TY - 1 && cur_c == TX - 1) fd_cyc = cyc + 1;
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        gaps    = 1'b0;
        spur_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_conv_start", conv_start, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_tile_row", tile_row, 0);
        chk("rst_tile_col", tile_col, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", in_ready, 1'b1);

        push_frame(0);
        wait_frames(1);
        gaps    = 1'b1;
        spur_en = 1'b1;
        push_frame(1);
        wait_frames(2);
        push_frame(2);
        wait_frames(3);

        // Abort a frame while tile (0,1) is being computed.
        push_frame(0);
        for (int k = 0; k < 3000 && !(active && cur_t == 0 && cur_c == 1); k++) @(negedge clk);
        chk("reached_tile_0_1", active && cur_c == 1, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_in_ready", in_ready, 1'b0);
        chk("async_rst_conv_start", conv_start, 1'b0);
        chk("async_rst_frame_done", frame_done, 1'b0);
        chk("async_rst_tile_row", tile_row, 0);
        chk("async_rst_tile_col", tile_col, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        push_frame(0);
        wait_frames(4);
        repeat (5) @(negedge clk);
        chk("no_pending_tiles", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
